// File: rtl/mem_arbiter.sv
// Single-port bus arbiter between instruction fetch (IF) and the memory stage (MEM).
// MEM normally wins a simultaneous request; IF wins once MEM has been granted four
// times in a row over a waiting IF. Each transaction is bounded by a bus timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  // Fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  // Load/store port
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  // Bus side
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  // Pipeline
  output logic        stallreq_o
);

  localparam int unsigned TmoW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGntIf,
    StGntMem,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      starve_q, starve_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            bus_we_q, bus_we_d;
  logic [31:0]     bus_addr_q, bus_addr_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;
  logic [3:0]      bus_sel_q, bus_sel_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     mem_rdata_q, mem_rdata_d;
  logic            if_ack_q, if_ack_d;
  logic            mem_ack_q, mem_ack_d;
  logic            bus_err_q, bus_err_d;

  // Arbitration, bus transaction tracking and response capture.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    bus_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (mem_req && ((starve_q < 3'd4) || !if_req)) begin
          state_d     = StGntMem;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          bus_sel_d   = mem_sel;
          // Only grants that made IF wait count towards starvation.
          if (if_req && (starve_q != 3'd7)) begin
            starve_d = starve_q + 3'd1;
          end
        end else if (if_req) begin
          state_d     = StGntIf;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = '0;
          bus_sel_d   = 4'b1111;
          starve_d    = '0;
        end
      end

      StGntIf, StGntMem: begin
        if (bus_ack) begin
          state_d = StDone;
          tmo_d   = '0;
          if (state_q == StGntIf) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus_rdata;
          end else begin
            mem_ack_d = 1'b1;
            if (!bus_we_q) begin
              mem_rdata_d = bus_rdata;
            end
          end
        end else if (tmo_q == TmoLast) begin
          // Slave never answered: complete with an error and all-ones data.
          state_d   = StDone;
          tmo_d     = '0;
          bus_err_d = 1'b1;
          if (state_q == StGntIf) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '1;
          end else begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = '1;
          end
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      tmo_q       <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus_req    = (state_q == StGntIf) || (state_q == StGntMem);
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_sel    = bus_sel_q;
  assign bus_err    = bus_err_q;
  assign if_rdata   = if_rdata_q;
  assign if_ack     = if_ack_q;
  assign mem_rdata  = mem_rdata_q;
  assign mem_ack    = mem_ack_q;
  assign stallreq_o = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by two randomized requesters
// against a wait-state slave, checked through per-requester expectation queues.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] if_rdata, mem_rdata;
  logic        if_ack, mem_ack;
  logic        bus_req, bus_we, bus_err, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;
  logic        stallreq_o;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .stallreq_o(stallreq_o)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] slv_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Slave: mode 0 random 0..3 wait states, 1 zero-wait with dir_rdata, 2 never acks.
  // stray 0 none, 1 random acks while idle, 2 ack every idle cycle.
  int          slv_mode  = 1;
  int          slv_stray = 0;
  logic [31:0] dir_rdata = '0;

  initial begin
    int wait_cnt, wait_tgt;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    wait_cnt  = 0;
    wait_tgt  = 0;
    forever begin
      tick();
      if (bus_req) begin
        if (slv_mode != 2 && wait_cnt >= wait_tgt) begin
          bus_ack   = 1'b1;
          bus_rdata = (slv_mode == 1) ? dir_rdata : slv_data(bus_addr);
        end else begin
          bus_ack   = 1'b0;
          bus_rdata = $urandom;
          wait_cnt++;
        end
      end else begin
        wait_cnt  = 0;
        wait_tgt  = (slv_mode == 0) ? int'($urandom_range(0, 3)) : 0;
        bus_ack   = (slv_stray == 2) ? 1'b1 : (slv_stray == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_rdata = $urandom;
      end
    end
  end

  // Scoreboard state
  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } mem_exp_t;

  logic [31:0] if_exp_q[$];
  mem_exp_t    mem_exp_q[$];
  logic        sb_en = 1'b0;
  logic [31:0] cur_if_addr, cur_mem_addr, cur_mem_wdata;
  logic        cur_mem_we;
  logic [3:0]  cur_mem_sel;

  int          m_starve = 0;
  logic [31:0] m_mem_last = '0;
  logic        m_done = 1'b0, m_win_mem = 1'b0;
  logic        m_prev_if = 1'b0, m_prev_mem = 1'b0, m_prev_bus = 1'b0;
  logic        e_we;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_sel;

  // Monitor: predicts each grant from the requests seen in the preceding idle cycle
  // and checks bus values, ack timing and returned data against the queues.
  always @(negedge clk) begin
    chk("stallreq", stallreq_o, (if_req & ~if_ack) | (mem_req & ~mem_ack));
    if (rst) begin
      m_starve   = 0;
      m_mem_last = '0;
      m_done     = 1'b0;
    end else if (sb_en) begin
      if (bus_req && !m_prev_bus) begin
        chk("grant_has_req", m_prev_if | m_prev_mem, 1);
        if (m_prev_mem && (m_starve < 4 || !m_prev_if)) begin
          m_win_mem = 1'b1;
          if (m_prev_if) m_starve++;
          e_we = cur_mem_we; e_addr = cur_mem_addr; e_wdata = cur_mem_wdata; e_sel = cur_mem_sel;
        end else begin
          m_win_mem = 1'b0;
          m_starve  = 0;
          e_we = 1'b0; e_addr = cur_if_addr; e_wdata = '0; e_sel = 4'hF;
        end
      end
      if (bus_req) begin
        chk("bus_we", bus_we, e_we);
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_wdata", bus_wdata, e_wdata);
        chk("bus_sel", bus_sel, e_sel);
      end
      chk("if_ack_timing", if_ack, m_done && !m_win_mem);
      chk("mem_ack_timing", mem_ack, m_done && m_win_mem);
      if (if_ack) begin
        chk("if_exp_avail", if_exp_q.size() != 0, 1);
        if (if_exp_q.size() != 0) chk("if_rdata", if_rdata, if_exp_q.pop_front());
      end
      if (mem_ack) begin
        chk("mem_exp_avail", mem_exp_q.size() != 0, 1);
        if (mem_exp_q.size() != 0) begin
          mem_exp_t e;
          e = mem_exp_q.pop_front();
          if (!e.we) m_mem_last = e.data;
          chk("mem_rdata", mem_rdata, m_mem_last);
        end
      end
      chk("bus_err_quiet", bus_err, 0);
      m_done = bus_req && bus_ack;
    end
    m_prev_if  = if_req;
    m_prev_mem = mem_req;
    m_prev_bus = bus_req;
  end

  task automatic if_agent(input int n);
    for (int i = 0; i < n; i++) begin
      logic ok;
      repeat ($urandom_range(1, 3)) tick();
      cur_if_addr = $urandom & 32'hFFFF_FFFC;
      if_addr     = cur_if_addr;
      if_exp_q.push_back(slv_data(cur_if_addr));
      if_req = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
        tick();
        if (if_ack) begin ok = 1'b1; break; end
      end
      if_req = 1'b0;
      chk("if_ack_wait", ok, 1);
    end
  endtask

  task automatic mem_agent(input int n);
    for (int i = 0; i < n; i++) begin
      logic ok;
      mem_exp_t e;
      repeat ($urandom_range(1, 3)) tick();
      cur_mem_we    = 1'($urandom_range(0, 1));
      cur_mem_addr  = $urandom & 32'hFFFF_FFFC;
      cur_mem_wdata = $urandom;
      cur_mem_sel   = 4'($urandom_range(0, 15));
      mem_we = cur_mem_we; mem_addr = cur_mem_addr;
      mem_wdata = cur_mem_wdata; mem_sel = cur_mem_sel;
      e.we   = cur_mem_we;
      e.data = slv_data(cur_mem_addr);
      mem_exp_q.push_back(e);
      mem_req = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
        tick();
        if (mem_ack) begin ok = 1'b1; break; end
      end
      mem_req = 1'b0;
      chk("mem_ack_wait", ok, 1);
    end
  endtask

  initial begin
    logic [31:0] got [5];
    int ngr, cnt;
    logic prev, seen;
    rst = 1'b1;
    if_req = 0; mem_req = 0; mem_we = 0; if_addr = '0; mem_addr = '0; mem_wdata = '0;
    mem_sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", bus_req, 0);   chk("rst_bus_sel", bus_sel, 0);
    chk("rst_if_ack", if_ack, 0);     chk("rst_mem_ack", mem_ack, 0);
    chk("rst_bus_err", bus_err, 0);   chk("rst_if_rdata", if_rdata, 0);
    tick();
    rst = 1'b0;

    // Zero-wait fetch
    dir_rdata = 32'h2402_0005;
    tick(); if_req = 1; if_addr = 32'h40;
    @(negedge clk); chk("t22_idle_bus_req", bus_req, 0);
    tick(); @(negedge clk);
    chk("t22_bus_req", bus_req, 1); chk("t22_bus_addr", bus_addr, 32'h40);
    chk("t22_bus_we", bus_we, 0);   chk("t22_bus_sel", bus_sel, 4'hF);
    chk("t22_early_ack", if_ack, 0);
    tick(); if_req = 0; @(negedge clk);
    chk("t22_if_ack", if_ack, 1); chk("t22_if_rdata", if_rdata, 32'h2402_0005);
    chk("t22_bus_req_off", bus_req, 0);
    tick(); @(negedge clk); chk("t22_ack_pulse", if_ack, 0);

    // Simultaneous requests: MEM write first, then IF
    dir_rdata = 32'h1111_2222;
    tick(); if_req = 1; if_addr = 32'h80; mem_req = 1; mem_we = 1; mem_addr = 32'h100;
    mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'b0011;
    tick(); @(negedge clk);
    chk("t23_m_we", bus_we, 1); chk("t23_m_addr", bus_addr, 32'h100);
    chk("t23_m_wdata", bus_wdata, 32'hDEAD_BEEF); chk("t23_m_sel", bus_sel, 4'b0011);
    chk("t23_stall", stallreq_o, 1);
    tick(); mem_req = 0; @(negedge clk);
    chk("t23_mem_ack", mem_ack, 1); chk("t23_wr_no_rdata", mem_rdata, 0);
    chk("t23_stall_if", stallreq_o, 1);
    tick(); tick(); @(negedge clk);
    chk("t23_i_addr", bus_addr, 32'h80); chk("t23_i_we", bus_we, 0);
    chk("t23_i_wdata", bus_wdata, 0);    chk("t23_i_sel", bus_sel, 4'hF);
    tick(); if_req = 0; @(negedge clk);
    chk("t23_if_ack", if_ack, 1); chk("t23_if_rdata", if_rdata, 32'h1111_2222);
    tick();

    // Starvation: four MEM grants then IF
    dir_rdata = 32'h3333_4444;
    tick(); mem_req = 1; mem_we = 0; mem_addr = 32'h200; mem_sel = 4'hF;
    if_req = 1; if_addr = 32'h300;
    ngr = 0; prev = 0;
    for (int c = 0; c < 60 && ngr < 5; c++) begin
      @(negedge clk);
      if (bus_req && !prev) begin got[ngr] = bus_addr; ngr++; end
      prev = bus_req;
    end
    tick(); if_req = 0; mem_req = 0;
    tick();
    chk("t24_grants", ngr, 5);
    for (int g = 0; g < 4; g++) chk("t24_mem_grant", got[g], 32'h200);
    chk("t24_if_grant", got[4], 32'h300);

    // Timeout
    slv_mode = 2;
    tick(); if_req = 1; if_addr = 32'h44;
    cnt = 0; seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus_err) begin seen = 1; break; end
      if (bus_req) cnt++;
    end
    chk("t25_err_seen", seen, 1); chk("t25_req_cycles", cnt, 16);
    chk("t25_if_ack", if_ack, 1); chk("t25_if_rdata", if_rdata, 32'hFFFF_FFFF);
    chk("t25_bus_req_off", bus_req, 0);
    tick(); if_req = 0; @(negedge clk);
    chk("t25_err_pulse", bus_err, 0); chk("t25_ack_pulse", if_ack, 0);
    chk("t25_idle", bus_req, 0);

    // Reset in the middle of a MEM grant
    tick(); mem_req = 1; mem_we = 0; mem_addr = 32'h500; mem_sel = 4'hF;
    tick(); @(negedge clk); chk("t26_granted", bus_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("t26_bus_req", bus_req, 0);     chk("t26_bus_addr", bus_addr, 0);
    chk("t26_bus_sel", bus_sel, 0);     chk("t26_mem_rdata", mem_rdata, 0);
    chk("t26_if_rdata", if_rdata, 0);   chk("t26_mem_ack", mem_ack, 0);
    slv_mode = 1; dir_rdata = 32'h5555_AAAA;
    tick(); tick(); @(negedge clk); chk("t26_no_ack", mem_ack, 0);
    tick(); rst = 1'b0;
    @(negedge clk); chk("t26_idle", bus_req, 0);
    tick(); @(negedge clk);
    chk("t26_regrant", bus_req, 1); chk("t26_regrant_addr", bus_addr, 32'h500);
    tick(); mem_req = 0; @(negedge clk);
    chk("t26_mem_ack", mem_ack, 1); chk("t26_rdata", mem_rdata, 32'h5555_AAAA);
    tick();

    // Stray acks while idle
    slv_stray = 2;
    repeat (4) begin
      tick(); @(negedge clk);
      chk("t27_if_ack", if_ack, 0);  chk("t27_mem_ack", mem_ack, 0);
      chk("t27_if_rdata", if_rdata, 0); chk("t27_mem_rdata", mem_rdata, 32'h5555_AAAA);
    end
    slv_stray = 0;

    // Randomized traffic
    tick(); rst = 1'b1;
    sb_en = 1'b1; slv_mode = 0; slv_stray = 1;
    tick(); tick(); rst = 1'b0;
    fork
      if_agent(40);
      mem_agent(40);
    join
    repeat (5) tick();
    sb_en = 1'b0;
    chk("if_queue_drained", if_exp_q.size(), 0);
    chk("mem_queue_drained", mem_exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
